// File: rtl/pps_sync_ctrl.sv
// pps_sync_ctrl: qualifies GPS PPS edges, timestamps them and sequences lock/holdover for the DDS correction loop.
// Optional PPS_DEGLITCH_EN requires DEGLITCH_CYCLES of synchronised high time before an edge counts.
module pps_sync_ctrl #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int QUALIFY_COUNT   = 3,
  parameter int TIMEOUT_WIDTH   = 28,
  parameter int DEGLITCH_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pps_in,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  input  logic                       cfg_enable,
  input  logic [31:0]                cfg_window,
  input  logic [TIMEOUT_WIDTH-1:0]   cfg_timeout,
  output logic [TIMESTAMP_WIDTH-1:0] time_pps,
  output logic                       pps_valid,
  output logic                       locked,
  output logic                       holdover,
  output logic [31:0]                pps_count,
  output logic [15:0]                bad_count,
  output logic [15:0]                miss_count
);
  typedef enum logic [2:0] {IDLE, ACQUIRE, QUALIFY, LOCKED, HOLDOVER} state_t;
  state_t state, nstate;
  logic s1, s2, edge_det, in_win, counting, tmo, fwd, nfwd, bad_inc, miss_inc;
  logic [TIMESTAMP_WIDTH-1:0] prev_ts, delta;
  logic [TIMEOUT_WIDTH-1:0] tcnt;
  logic [3:0] qual, nqual;
`ifdef PPS_DEGLITCH_EN
  localparam int DW = $clog2(DEGLITCH_CYCLES + 1);
  logic [DW-1:0] dg;
  always_ff @(posedge clk or posedge reset)
    if (reset) dg <= '0;
    else dg <= !s2 ? '0 : (dg == DW'(DEGLITCH_CYCLES)) ? dg : dg + 1'b1;
  assign edge_det = s2 && dg == DW'(DEGLITCH_CYCLES - 1);
`else
  logic s3;
  always_ff @(posedge clk or posedge reset)
    if (reset) s3 <= 1'b0;
    else s3 <= s2;
  assign edge_det = s2 & ~s3;
`endif
  assign delta    = timestamp - prev_ts;
  // ~lo < window on the early side makes the window symmetric around exactly 1 s
  assign in_win   = (delta[TIMESTAMP_WIDTH-1:32] == 1 && delta[31:0] <= cfg_window) ||
                    (delta[TIMESTAMP_WIDTH-1:32] == 0 && ~delta[31:0] < cfg_window);
  assign counting = state == QUALIFY || state == LOCKED;
  assign tmo      = counting && !edge_det && tcnt == cfg_timeout;
  assign locked   = state == LOCKED;
  assign holdover = state == HOLDOVER;
  always_comb begin
    nstate   = state;
    nqual    = qual;
    nfwd     = 1'b0;
    bad_inc  = 1'b0;
    miss_inc = 1'b0;
    if (!cfg_enable) nstate = IDLE;
    else case (state)
      IDLE:    nstate = ACQUIRE;
      ACQUIRE: if (edge_det) begin nstate = QUALIFY; nqual = '0; end
      QUALIFY:
        if (edge_det && in_win) begin
          nqual = qual + 1'b1;
          if (nqual >= 4'(QUALIFY_COUNT)) begin nstate = LOCKED; nfwd = 1'b1; end
        end else if (edge_det) begin
          nqual   = '0;
          bad_inc = 1'b1;
        end else if (tmo) begin
          nstate   = ACQUIRE;
          miss_inc = 1'b1;
        end
      LOCKED:
        if (edge_det && in_win) nfwd = 1'b1;
        else if (edge_det) begin
          nstate  = QUALIFY;
          nqual   = '0;
          bad_inc = 1'b1;
        end else if (tmo) begin
          nstate   = HOLDOVER;
          miss_inc = 1'b1;
        end
      HOLDOVER: if (edge_det) begin nstate = QUALIFY; nqual = '0; end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      prev_ts    <= '0;
      tcnt       <= '0;
      state      <= IDLE;
      qual       <= '0;
      fwd        <= 1'b0;
      time_pps   <= '0;
      pps_valid  <= 1'b0;
      pps_count  <= '0;
      bad_count  <= '0;
      miss_count <= '0;
    end else begin
      s1        <= pps_in;
      s2        <= s1;
      prev_ts   <= edge_det ? timestamp : prev_ts;
      tcnt      <= (edge_det || !counting || tmo) ? '0 : tcnt + 1'b1;
      state     <= nstate;
      qual      <= nqual;
      fwd       <= nfwd;
      pps_valid <= fwd && cfg_enable;
      // prev_ts still holds the captured edge timestamp one cycle after E
      time_pps   <= (fwd && cfg_enable) ? prev_ts : time_pps;
      pps_count  <= pps_count + 32'(fwd && cfg_enable);
      bad_count  <= bad_count + 16'(bad_inc && bad_count != 16'hFFFF);
      miss_count <= miss_count + 16'(miss_inc && miss_count != 16'hFFFF);
    end
endmodule

// File: tb/tb_pps_sync_ctrl.sv
// tb_pps_sync_ctrl: directed plus randomized PPS pulses checked against an event-level reference model.
module tb_pps_sync_ctrl;
`ifdef PPS_DEGLITCH_EN
  localparam int LAT = 8 + 3;
`else
  localparam int LAT = 4;
`endif
  localparam int MI = 0, MA = 1, MQ = 2, ML = 3, MH = 4, QC = 3;
  logic clk = 0, reset, pps_in, cfg_enable, pps_valid, locked, holdover;
  logic [63:0] timestamp, time_pps;
  logic [31:0] cfg_window, pps_count;
  logic [27:0] cfg_timeout;
  logic [15:0] bad_count, miss_count;
  int n_checks = 0, n_err = 0, cyc = 0;
  int m_st, m_q, m_pc, m_bad, m_miss;
  logic [63:0] m_prev;

  pps_sync_ctrl #(.TIMESTAMP_WIDTH(64), .QUALIFY_COUNT(QC), .TIMEOUT_WIDTH(28), .DEGLITCH_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .pps_in(pps_in), .timestamp(timestamp), .cfg_enable(cfg_enable),
    .cfg_window(cfg_window), .cfg_timeout(cfg_timeout), .time_pps(time_pps), .pps_valid(pps_valid),
    .locked(locked), .holdover(holdover), .pps_count(pps_count), .bad_count(bad_count), .miss_count(miss_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = MI; m_q = 0; m_pc = 0; m_bad = 0; m_miss = 0; m_prev = 0;
  endtask

  // Event-level model: a qualified second is 1 s +/- cfg_window, inclusive on both sides
  task automatic model_edge(input logic [63:0] ts, input bit drop, output bit f);
    longint dev = longint'(ts - m_prev - 64'h1_0000_0000);
    longint w = longint'({32'b0, cfg_window});
    bit win = dev >= -w && dev <= w;
    m_prev = ts;
    f = 0;
    if (m_st == MA || m_st == MH) begin m_st = MQ; m_q = 0; end
    else if (m_st == MQ && win) begin
      m_q++;
      if (m_q == QC) begin m_st = ML; f = 1; end
    end else if (m_st == MQ || (m_st == ML && !win)) begin
      m_st = MQ; m_q = 0;
      if (m_bad < 16'hFFFF) m_bad++;
    end else if (m_st == ML) f = 1;
    if (drop) begin f = 0; m_st = MI; end
    if (f) m_pc++;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".locked"}, 64'(locked), 64'(m_st == ML));
    chk({tag, ".holdover"}, 64'(holdover), 64'(m_st == MH));
    chk({tag, ".pps_count"}, 64'(pps_count), 64'(m_pc));
    chk({tag, ".bad_count"}, 64'(bad_count), 64'(m_bad));
    chk({tag, ".miss_count"}, 64'(miss_count), 64'(m_miss));
  endtask

  task automatic pulse(input string tag, input logic [63:0] ts, input int hi, input bit drop, input bit ign);
    int nv = 0, lat = 0;
    bit f = 0;
    timestamp = ts;
    @(negedge clk);
    pps_in = 1;
    for (int k = 1; k <= LAT + 8; k++) begin
      @(posedge clk); #1;
      if (k == hi) pps_in = 0;
      if (drop && k == LAT - 1) cfg_enable = 0;
      if (pps_valid) begin
        if (nv == 0) lat = k;
        nv++;
      end
    end
    pps_in = 0;
    repeat (4) @(posedge clk);
    #1;
    if (!ign) model_edge(ts, drop, f);
    chk({tag, ".strobes"}, 64'(nv), 64'(f));
    if (f) begin
      chk({tag, ".latency"}, 64'(lat), 64'(LAT));
      chk({tag, ".time_pps"}, time_pps, ts);
    end
    check_status(tag);
  endtask

  task automatic enable_on();
    @(negedge clk);
    cfg_enable = 1;
    repeat (3) @(posedge clk);
    #1;
    m_st = MA;
  endtask

  initial begin
    int ho_at, c0, w;
    longint dv;
    reset = 1; pps_in = 0; cfg_enable = 0; cfg_window = 32'h100; cfg_timeout = 28'd5000; timestamp = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.time_pps", time_pps, 0);
    chk("rst.pps_valid", 64'(pps_valid), 0);
    check_status("rst");
    @(negedge clk);
    reset = 0;
    enable_on();
    for (int i = 1; i <= 4; i++) pulse("acq", 64'(i) << 32, 10, 0, 0);
    chk("acq.locked4", 64'(locked), 1);
    pulse("win_late", m_prev + 64'h1_0000_0080, 10, 0, 0);
    pulse("win_early", m_prev + 64'h0_FFFF_FE00, 10, 0, 0);
    chk("win_early.bad", 64'(bad_count), 1);
    for (int i = 0; i < 3; i++) pulse("relock", m_prev + 64'h1_0000_0000, 10, 0, 0);
    cfg_timeout = 28'd1000;
    c0 = cyc - (LAT + 12);
    ho_at = -1;
    for (int i = 0; i < 1500 && ho_at < 0; i++) begin
      @(posedge clk); #1;
      if (holdover) ho_at = cyc - c0;
    end
    m_st = MH;
    m_miss++;
    chk("timeout.seen", 64'(ho_at >= LAT + 995 && ho_at <= LAT + 1005), 1);
    check_status("timeout");
    cfg_timeout = 28'd5000;
    pulse("from_ho", m_prev + 64'h1_0000_0000, 10, 0, 0);
    for (int i = 0; i < 3; i++) pulse("relock2", m_prev + 64'h1_0000_0000, 10, 0, 0);
    pulse("en_drop", m_prev + 64'h1_0000_0000, 10, 1, 0);
    enable_on();
    pulse("q1", m_prev + 64'h1_0000_0000, 10, 0, 0);
    pulse("q2", m_prev + 64'h1_0000_0000, 10, 0, 0);
    @(posedge clk);
    #3 reset = 1;
    #1;
    model_reset();
    chk("arst.time_pps", time_pps, 0);
    chk("arst.pps_valid", 64'(pps_valid), 0);
    check_status("arst");
    @(negedge clk);
    reset = 0;
    enable_on();
    for (int i = 4; i >= 1; i--) pulse("wrap_acq", 64'h0000_0000_8000_0000 - (64'(i) << 32), 10, 0, 0);
    pulse("wrap", 64'h0000_0000_8000_0000, 10, 0, 0);
`ifdef PPS_DEGLITCH_EN
    pulse("glitch5", m_prev + 64'h1_0000_0000, 5, 0, 1);
    pulse("deglitch8", m_prev + 64'h1_0000_0000, 8, 0, 0);
`endif
    for (int i = 0; i < 40; i++) begin
      w = int'($urandom_range(0, 4096));
      cfg_window = 32'(w);
      dv = longint'($urandom_range(0, 4 * w + 4)) - 2 * w - 2;
      if ($urandom_range(0, 7) == 0) dv = longint'($urandom) - 64'h8000_0000;
      pulse("rand", m_prev + 64'h1_0000_0000 + 64'(dv), 10, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
